// File: rtl/sram_a_loader.sv
// rtl/sram_a_loader.sv - scatters a raster 28x28 pixel stream into the nine interleaved SRAM_a banks
// Optional SRAM_A_LOADER_CLEAR_EN: zero every bank word before loading.
module sram_a_loader #(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int IMG_SIZE               = 28
) (
    input  logic                                         clk,
    input  logic                                         srstn,
    input  logic                                         start,
    input  logic                                         pix_valid,
    input  logic [DATA_WIDTH-1:0]                        pix_data,
    output logic                                         pix_ready,
    output logic                                         sram_write_enable_a0,
    output logic                                         sram_write_enable_a1,
    output logic                                         sram_write_enable_a2,
    output logic                                         sram_write_enable_a3,
    output logic                                         sram_write_enable_a4,
    output logic                                         sram_write_enable_a5,
    output logic                                         sram_write_enable_a6,
    output logic                                         sram_write_enable_a7,
    output logic                                         sram_write_enable_a8,
    output logic [DATA_NUM_PER_SRAM_ADDR-1:0]            sram_bytemask_a,
    output logic [9:0]                                   sram_waddr_a,
    output logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_wdata_a,
    output logic                                         busy,
    output logic                                         load_done
);

    localparam int NB    = DATA_NUM_PER_SRAM_ADDR;
    localparam int NW    = NB * DATA_WIDTH;
    localparam int CW    = $clog2(IMG_SIZE);
    localparam int TPR   = (IMG_SIZE + 5) / 6;

`ifdef SRAM_A_LOADER_CLEAR_EN
    localparam int AW    = $clog2(TPR * TPR);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;
    logic [AW-1:0] a_q, a_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   r_q, r_d, c_q, c_d;
    logic [8:0]      we_q, we_d;
    logic [NB-1:0]   mask_q, mask_d;
    logic [9:0]      waddr_q, waddr_d;
    logic [NW-1:0]   wdata_q, wdata_d;
    logic            busy_q, load_done_q;

    logic            hs, last_pix;
    logic [CW-1:0]   tr, tc;
    logic [3:0]      bank;
    logic [9:0]      addr;
    logic [1:0]      lane;

    assign pix_ready = (state_q == S_LOAD);
    assign hs        = pix_ready & pix_valid;
    assign last_pix  = (r_q == CW'(IMG_SIZE - 1)) && (c_q == CW'(IMG_SIZE - 1));

    // 2x2 pixel tiles are spread over a 3x3 bank grid; the bank-local address walks tiles of 3x3
    assign tr   = r_q >> 1;
    assign tc   = c_q >> 1;
    assign bank = 4'(((32'(tr) % 3) * 3) + (32'(tc) % 3));
    assign addr = 10'(((32'(tr) / 3) * TPR) + (32'(tc) / 3));
    assign lane = {r_q[0], c_q[0]};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        we_d    = '0;
        mask_d  = '1;
        waddr_d = '0;
        wdata_d = '0;
`ifdef SRAM_A_LOADER_CLEAR_EN
        a_d     = a_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d = '0;
                    c_d = '0;
`ifdef SRAM_A_LOADER_CLEAR_EN
                    a_d     = '0;
                    state_d = S_CLEAR;
`else
                    state_d = S_LOAD;
`endif
                end
            end
`ifdef SRAM_A_LOADER_CLEAR_EN
            S_CLEAR: begin
                we_d    = '1;
                mask_d  = '0;
                waddr_d = 10'(a_q);
                if (a_q == AW'(TPR * TPR - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    a_d = a_q + 1'b1;
                end
            end
`endif
            S_LOAD: begin
                if (hs) begin
                    we_d    = 9'(1) << bank;
                    waddr_d = addr;
                    // lane 0 lives in the top byte, so its mask bit is the MSB
                    mask_d  = ~(NB'(1) << ~lane);
                    wdata_d = {NB{pix_data}};
                    if (c_q == CW'(IMG_SIZE - 1)) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                    if (last_pix) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            we_q        <= '0;
            mask_q      <= '1;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
`ifdef SRAM_A_LOADER_CLEAR_EN
            a_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= (state_d != S_IDLE);
            // DONE coincides with the final write; the pulse follows it by one cycle
            load_done_q <= (state_q == S_DONE);
`ifdef SRAM_A_LOADER_CLEAR_EN
            a_q         <= a_d;
`endif
        end
    end

    assign {sram_write_enable_a8, sram_write_enable_a7, sram_write_enable_a6,
            sram_write_enable_a5, sram_write_enable_a4, sram_write_enable_a3,
            sram_write_enable_a2, sram_write_enable_a1, sram_write_enable_a0} = we_q;
    assign sram_bytemask_a = mask_q;
    assign sram_waddr_a    = waddr_q;
    assign sram_wdata_a    = wdata_q;
    assign busy            = busy_q;
    assign load_done       = load_done_q;

endmodule

// File: tb/tb_sram_a_loader.sv
// tb/tb_sram_a_loader.sv - randomized self-checking bench for sram_a_loader against a mapping model
module tb_sram_a_loader;

    localparam int N    = 28;
    localparam int NPIX = N * N;

    logic        clk = 1'b0;
    logic        srstn;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        we0, we1, we2, we3, we4, we5, we6, we7, we8;
    logic [3:0]  bytemask;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        load_done;
    logic [8:0]  en;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  img [NPIX];
    logic [31:0] mem  [9][25];
    logic [31:0] gold [9][25];
    int          dut_writes;

    assign en = {we8, we7, we6, we5, we4, we3, we2, we1, we0};

    sram_a_loader dut (
        .clk                  (clk),
        .srstn                (srstn),
        .start                (start),
        .pix_valid            (pix_valid),
        .pix_data             (pix_data),
        .pix_ready            (pix_ready),
        .sram_write_enable_a0 (we0),
        .sram_write_enable_a1 (we1),
        .sram_write_enable_a2 (we2),
        .sram_write_enable_a3 (we3),
        .sram_write_enable_a4 (we4),
        .sram_write_enable_a5 (we5),
        .sram_write_enable_a6 (we6),
        .sram_write_enable_a7 (we7),
        .sram_write_enable_a8 (we8),
        .sram_bytemask_a      (bytemask),
        .sram_waddr_a         (waddr),
        .sram_wdata_a         (wdata),
        .busy                 (busy),
        .load_done            (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, en, 9'h000);
        check({tag, "_mask"}, bytemask, 4'hF);
        check({tag, "_waddr"}, waddr, 10'd0);
        check({tag, "_wdata"}, wdata, 32'h0);
    endtask

    // Apply whatever the DUT presents this cycle to the SRAM model
    task automatic capture_writes();
        if (en != 9'h000) dut_writes++;
        for (int b = 0; b < 9; b++) begin
            if (en[b] && waddr < 10'd25) begin
                for (int l = 0; l < 4; l++) begin
                    if (!bytemask[3-l])
                        mem[b][waddr][(3-l)*8 +: 8] = wdata[(3-l)*8 +: 8];
                end
            end
        end
    endtask

    task automatic check_pixel_write(input int k);
        int r, c, bank, addr, lane;
        logic [3:0] exp_mask;
        r        = k / N;
        c        = k % N;
        bank     = ((r / 2) % 3) * 3 + (c / 2) % 3;
        addr     = (r / 6) * 5 + c / 6;
        lane     = (r % 2) * 2 + c % 2;
        exp_mask = 4'(15 - (8 >> lane));
        check("wr_en", en, 64'(1) << bank);
        check("wr_waddr", waddr, addr);
        check("wr_mask", bytemask, exp_mask);
        check("wr_wdata", wdata, {4{img[k]}});
        gold[bank][addr][(3-lane)*8 +: 8] = img[k];
        if (k == 0) begin
            check("px00_en", en, 9'h001);
            check("px00_waddr", waddr, 10'd0);
            check("px00_mask", bytemask, 4'b0111);
            check("px00_wdata", wdata, 32'h11111111);
        end
        if (k == 1) begin
            check("px01_en", en, 9'h001);
            check("px01_mask", bytemask, 4'b1011);
        end
        if (k == 2 * N + 6) begin
            check("px26_en", en, 9'h008);
            check("px26_waddr", waddr, 10'd1);
            check("px26_mask", bytemask, 4'b0111);
        end
        if (k == NPIX - 1) begin
            check("pxlast_en", en, 9'h010);
            check("pxlast_waddr", waddr, 10'd24);
            check("pxlast_mask", bytemask, 4'b1110);
            check("pxlast_wdata", wdata, 32'hC3C3C3C3);
        end
    endtask

    task automatic run_load(input int gap_pct, input int start_at, input int reset_at);
        int  k, cyc;
        bit  hs, aborted;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        img[0]         = 8'h11;
        img[2 * N + 6] = 8'h5A;
        img[NPIX - 1]  = 8'hC3;
        for (int b = 0; b < 9; b++)
            for (int a = 0; a < 25; a++) begin
                mem[b][a]  = 32'h0;
                gold[b][a] = 32'h0;
            end
        dut_writes = 0;
        aborted    = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check_idle_outputs("first_load_cycle");
        k   = 0;
        cyc = 0;
        while (k < NPIX && cyc < 20000 && !aborted) begin
            pix_valid = ($urandom_range(99) >= gap_pct);
            pix_data  = img[k];
            start     = (start_at >= 0 && k == start_at);
            check("ready_in_load", pix_ready, 1'b1);
            hs = pix_valid && pix_ready;
            if (reset_at >= 0 && k == reset_at) begin
                srstn = 1'b0;
                step();
                srstn     = 1'b1;
                pix_valid = 1'b0;
                start     = 1'b0;
                check("rst_ready", pix_ready, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", load_done, 1'b0);
                check_idle_outputs("rst");
                aborted = 1'b1;
            end else begin
                step();
                start = 1'b0;
                cyc++;
                capture_writes();
                if (hs) begin
                    check_pixel_write(k);
                    k++;
                end else begin
                    check_idle_outputs("gap");
                end
            end
        end
        pix_valid = 1'b0;
        if (!aborted) begin
            check("load_timeout", cyc < 20000, 1'b1);
            check("busy_last_write", busy, 1'b1);
            check("done_last_write", load_done, 1'b0);
            check("ready_last_write", pix_ready, 1'b0);
            step();
            capture_writes();
            check("done_pulse", load_done, 1'b1);
            check("busy_at_done", busy, 1'b0);
            check("ready_at_done", pix_ready, 1'b0);
            check_idle_outputs("at_done");
            step();
            check("done_one_cycle", load_done, 1'b0);
            check("write_count", dut_writes, NPIX);
            for (int b = 0; b < 9; b++)
                for (int a = 0; a < 25; a++)
                    check($sformatf("mem_b%0d_a%0d", b, a), mem[b][a], gold[b][a]);
        end
    endtask

    initial begin
        srstn     = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        repeat (3) step();
        check("reset_ready", pix_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", load_done, 1'b0);
        check_idle_outputs("reset");
        srstn = 1'b1;
        step();
        check("idle_ready", pix_ready, 1'b0);

        run_load(0, -1, -1);
        repeat (2) step();
        run_load(30, 100, -1);
        repeat (2) step();
        run_load(30, -1, 300);
        step();
        check("post_rst_idle_ready", pix_ready, 1'b0);
        run_load(0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
